// File: rtl/pll_cfg_seq_if.sv
// Configuration request channel into pll_cfg_seq: one divider/enable update per handshake.
interface pll_cfg_seq_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_sel;
    logic [3:0] cfg_fb;
    logic [3:0] cfg_out;
    logic       cfg_en;

    modport master (output cfg_valid, output cfg_sel, output cfg_fb, output cfg_out,
                    output cfg_en, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_sel, input cfg_fb, input cfg_out,
                    input cfg_en, output cfg_ready);
endinterface

// File: rtl/pll_cfg_seq.sv
// Four-channel PLL macro controller: sequences disable -> apply dividers -> re-enable ->
// settle -> ADC duty measurement for one channel per accepted request.
module pll_cfg_seq #(
    parameter int unsigned DIS_CYC    = 4,
    parameter int unsigned SETTLE_CYC = 1024,
    parameter int unsigned ADC_WIN    = 256,
    parameter logic [3:0]  DIV_RST    = 4'd1,
    localparam int unsigned ADC_W     = $clog2(ADC_WIN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    pll_cfg_seq_if.slave      cfg,
    output logic [15:0]       div_fb,
    output logic [15:0]       div_out,
    output logic [3:0]        enb,
    input  logic              adc_in,
    output logic [3:0]        locked,
    output logic [ADC_W-1:0]  adc_count,
    output logic              done
);

    localparam int unsigned MAX_A   = (SETTLE_CYC > ADC_WIN) ? SETTLE_CYC : ADC_WIN;
    localparam int unsigned MAX_CYC = (MAX_A > DIS_CYC) ? MAX_A : DIS_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {IDLE, DISABLE, APPLY, SETTLE, MEASURE} state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [ADC_W-1:0]   samp_q, samp_n, samp_inc;
    logic [1:0]         sel_q, sel_n;
    logic [3:0]         fb_q, fb_n, out_q, out_n;
    logic               en_q, en_n;
    logic [15:0]        div_fb_n, div_out_n;
    logic [3:0]         enb_n, locked_n;
    logic [ADC_W-1:0]   adc_count_n;
    logic               done_n, ready_q, ready_n;
    logic               adc_meta, adc_s;
    logic               accept;

    assign cfg.cfg_ready = ready_q;
    assign accept        = cfg.cfg_valid && ready_q;

    // adc_in is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_meta <= 1'b0;
            adc_s    <= 1'b0;
        end else begin
            adc_meta <= adc_in;
            adc_s    <= adc_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            samp_q    <= '0;
            sel_q     <= '0;
            fb_q      <= '0;
            out_q     <= '0;
            en_q      <= 1'b0;
            div_fb    <= {4{DIV_RST}};
            div_out   <= {4{DIV_RST}};
            enb       <= 4'hF;
            locked    <= 4'h0;
            adc_count <= '0;
            done      <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            samp_q    <= samp_n;
            sel_q     <= sel_n;
            fb_q      <= fb_n;
            out_q     <= out_n;
            en_q      <= en_n;
            div_fb    <= div_fb_n;
            div_out   <= div_out_n;
            enb       <= enb_n;
            locked    <= locked_n;
            adc_count <= adc_count_n;
            done      <= done_n;
            ready_q   <= ready_n;
        end
    end

    // Next state, counters and macro pin updates; only channel sel_q is ever touched.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        samp_n      = samp_q;
        sel_n       = sel_q;
        fb_n        = fb_q;
        out_n       = out_q;
        en_n        = en_q;
        div_fb_n    = div_fb;
        div_out_n   = div_out;
        enb_n       = enb;
        locked_n    = locked;
        adc_count_n = adc_count;
        done_n      = 1'b0;
        samp_inc    = (samp_q >= ADC_W'(ADC_WIN)) ? samp_q : samp_q + ADC_W'(adc_s);

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sel_n                 = cfg.cfg_sel;
                    fb_n                  = cfg.cfg_fb;
                    out_n                 = cfg.cfg_out;
                    en_n                  = cfg.cfg_en;
                    enb_n[cfg.cfg_sel]    = 1'b1;
                    locked_n[cfg.cfg_sel] = 1'b0;
                    cnt_n                 = CNT_W'(DIS_CYC - 1);
                    state_n               = DISABLE;
                end
            end
            DISABLE: begin
                if (cnt_q == '0) begin
                    cnt_n   = '0;
                    state_n = APPLY;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            APPLY: begin
                // Dividers move while the channel is still disabled; enable follows on the same edge.
                div_fb_n[{sel_q, 2'b00} +: 4]  = fb_q;
                div_out_n[{sel_q, 2'b00} +: 4] = out_q;
                if (en_q) begin
                    enb_n[sel_q] = 1'b0;
                    cnt_n        = CNT_W'(SETTLE_CYC - 1);
                    state_n      = SETTLE;
                end else begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    cnt_n   = CNT_W'(ADC_WIN - 1);
                    samp_n  = '0;
                    state_n = MEASURE;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            MEASURE: begin
                samp_n = samp_inc;
                if (cnt_q == '0) begin
                    adc_count_n     = samp_inc;
                    locked_n[sel_q] = 1'b1;
                    done_n          = 1'b1;
                    state_n         = IDLE;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        ready_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Scoreboard bench for pll_cfg_seq: accept monitor models expected results, done monitor checks them.
module tb_pll_cfg_seq;
    localparam int unsigned DIS = 4;
    localparam int unsigned SET = 16;
    localparam int unsigned WIN = 8;
    localparam int LAT_EN  = DIS + 1 + SET + WIN;
    localparam int LAT_DIS = DIS + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        adc_in = 1'b0;
    logic [15:0] div_fb, div_out;
    logic [3:0]  enb, locked;
    logic [3:0]  adc_count;
    logic        done;

    pll_cfg_seq_if cfg_bus();

    pll_cfg_seq #(.DIS_CYC(DIS), .SETTLE_CYC(SET), .ADC_WIN(WIN), .DIV_RST(4'd1)) dut (
        .clk(clk), .rst_n(rst_n), .cfg(cfg_bus),
        .div_fb(div_fb), .div_out(div_out), .enb(enb),
        .adc_in(adc_in), .locked(locked), .adc_count(adc_count), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        int          acc_cyc;
        logic [3:0]  lck;
        int          adc_lo;
        int          adc_hi;
        logic [15:0] fb;
        logic [15:0] out;
        logic [3:0]  enb;
    } exp_t;

    exp_t        exp_q[$];
    int          rd_idx = 0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          adc_mode = 0;
    logic [3:0]  m_locked, m_enb;
    logic [15:0] m_fb, m_out;
    int          m_lo, m_hi;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // adc stimulus: 0 = low, 1 = high, 2 = toggle every cycle
    initial forever begin
        @(negedge clk);
        adc_in = (adc_mode == 2) ? ~adc_in : (adc_mode == 1);
    end

    // Accept monitor: build the expected post-sequence snapshot for each accepted request
    always @(posedge clk or negedge rst_n) begin : acc_mon
        exp_t e;
        int   idx;
        if (!rst_n) begin
            m_locked <= 4'h0;
            m_enb    <= 4'hF;
            m_fb     <= 16'h1111;
            m_out    <= 16'h1111;
            m_lo     <= 0;
            m_hi     <= 0;
            exp_q.delete();
        end else if (cfg_bus.cfg_valid && cfg_bus.cfg_ready) begin
            idx              = 4 * int'(cfg_bus.cfg_sel);
            e.en             = cfg_bus.cfg_en;
            e.acc_cyc        = cyc + 1;
            e.lck            = m_locked;
            e.lck[cfg_bus.cfg_sel] = cfg_bus.cfg_en;
            e.enb            = m_enb;
            e.enb[cfg_bus.cfg_sel] = ~cfg_bus.cfg_en;
            e.fb             = m_fb;
            e.fb[idx +: 4]   = cfg_bus.cfg_fb;
            e.out            = m_out;
            e.out[idx +: 4]  = cfg_bus.cfg_out;
            if (cfg_bus.cfg_en) begin
                e.adc_lo = (adc_mode == 2) ? 3 : (adc_mode == 1) ? 8 : 0;
                e.adc_hi = (adc_mode == 2) ? 5 : (adc_mode == 1) ? 8 : 0;
            end else begin
                e.adc_lo = m_lo;
                e.adc_hi = m_hi;
            end
            m_locked <= e.lck;
            m_enb    <= e.enb;
            m_fb     <= e.fb;
            m_out    <= e.out;
            m_lo     <= e.adc_lo;
            m_hi     <= e.adc_hi;
            exp_q.push_back(e);
        end
    end

    // Done monitor: ready tracking plus scoreboard comparison on every done pulse
    always @(negedge clk) begin : done_mon
        exp_t e;
        if (!rst_n) begin
            rd_idx = 0;
        end else begin
            chk("cfg_ready", int'(cfg_bus.cfg_ready), int'((exp_q.size() == rd_idx) || done));
            if (done) begin
                if (rd_idx >= exp_q.size()) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = exp_q[rd_idx];
                    rd_idx++;
                    chk("latency", cyc - e.acc_cyc, e.en ? LAT_EN : LAT_DIS);
                    chk("locked", int'(locked), int'(e.lck));
                    chk("enb", int'(enb), int'(e.enb));
                    chk("div_fb", int'(div_fb), int'(e.fb));
                    chk("div_out", int'(div_out), int'(e.out));
                    chk("adc_count_in_range",
                        int'(int'(adc_count) >= e.adc_lo && int'(adc_count) <= e.adc_hi), 1);
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!cfg_bus.cfg_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(cfg_bus.cfg_ready), 1);
    endtask

    task automatic send(input logic [1:0] s, input logic [3:0] f, input logic [3:0] o, input logic e);
        @(negedge clk);
        cfg_bus.cfg_sel   = s;
        cfg_bus.cfg_fb    = f;
        cfg_bus.cfg_out   = o;
        cfg_bus.cfg_en    = e;
        cfg_bus.cfg_valid = 1'b1;
        wait_ready("send_ready");
        @(posedge clk);
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == rd_idx && cfg_bus.cfg_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", int'(n < 200), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_enb"}, int'(enb), 4'hF);
        chk({tag, "_div_fb"}, int'(div_fb), 16'h1111);
        chk({tag, "_div_out"}, int'(div_out), 16'h1111);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_ready"}, int'(cfg_bus.cfg_ready), 1);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_adc_count"}, int'(adc_count), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int          hi;
        int          prev;
        int          base_acc;
        int          base_done;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_sel   = 2'd0;
        cfg_bus.cfg_fb    = 4'd0;
        cfg_bus.cfg_out   = 4'd0;
        cfg_bus.cfg_en    = 1'b0;

        #2 rst_n = 1'b0;
        #1 chk_reset_vals("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic sequence on channel 2 with adc held high
        adc_mode = 1;
        send(2'd2, 4'd5, 4'd3, 1'b1);
        hi = 0;
        prev = 0;
        while (enb[2] && hi < 100) begin
            prev = int'(div_fb[11:8]);
            hi++;
            @(negedge clk);
        end
        chk("enb2_disabled_cycles", hi, 5);
        chk("fb2_before_enable", prev, 1);
        chk("fb2_at_enable", int'(div_fb[11:8]), 5);
        chk("out2_at_enable", int'(div_out[11:8]), 3);
        wait_idle();
        chk("basic_locked", int'(locked), 4'b0100);
        chk("basic_adc_count", int'(adc_count), 8);

        // Disable request on channel 2: adc_count must hold
        send(2'd2, 4'd7, 4'd2, 1'b0);
        wait_idle();
        chk("dis_locked", int'(locked), 0);
        chk("dis_fb2", int'(div_fb[11:8]), 7);
        chk("dis_enb2", int'(enb[2]), 1);
        chk("dis_adc_count", int'(adc_count), 8);

        // Toggling adc on channel 3
        adc_mode = 2;
        send(2'd3, 4'd2, 4'd4, 1'b1);
        wait_idle();

        // Channel 1 request held while channel 0 is busy
        adc_mode = 0;
        send(2'd0, 4'd9, 4'd2, 1'b1);
        send(2'd1, 4'd4, 4'd6, 1'b1);
        wait_idle();
        chk("iso_locked", int'(locked), 4'b1011);
        chk("iso_div_fb", int'(div_fb), 16'h2749);
        chk("iso_div_out", int'(div_out), 16'h4262);
        chk("iso_enb", int'(enb), 4'b0100);
        chk("iso_adc_count", int'(adc_count), 0);

        // Asynchronous reset in the middle of MEASURE
        adc_mode = 1;
        send(2'd1, 4'd3, 4'd3, 1'b1);
        repeat (DIS + 1 + SET + 3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back requests with valid held high and alternating channels
        base_acc  = exp_q.size();
        base_done = rd_idx;
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cfg_bus.cfg_sel = 2'(k % 2);
            cfg_bus.cfg_fb  = 4'(k + 2);
            cfg_bus.cfg_out = 4'(k + 8);
            cfg_bus.cfg_en  = (k != 2);
            wait_ready("b2b_ready");
            @(posedge clk);
            @(negedge clk);
        end
        cfg_bus.cfg_valid = 1'b0;
        wait_idle();
        chk("b2b_accepts", exp_q.size() - base_acc, 4);
        chk("b2b_dones", rd_idx - base_done, 4);
        chk("b2b_locked", int'(locked), 4'b0010);
        chk("b2b_div_fb", int'(div_fb), 16'h1154);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
